// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative, write-back, write-allocate cache with
// one data word per line and per-set round-robin replacement.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata      requester access, sampled only in IDLE
//   cpu_rdata, cpu_ready       read data and one-cycle completion pulse
//   mem_req/we/addr/wdata      backing-memory request, held until mem_ack
//   mem_rdata, mem_ack         refill data and memory completion
//
// Optional feature: define ASSOC_WB_CACHE_STATS_EN to add the 32-bit
// hit_cnt, miss_cnt and wb_cnt counter outputs.
module assoc_wb_cache #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int SETS   = 64,
    parameter int WAYS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
`ifdef ASSOC_WB_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_INSTALL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Line storage: tag/data carry no reset, only the valid/dirty/RR control state does.
    logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
    logic [DATA_W-1:0]   data_q  [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAY_W-1:0]    rr_q    [SETS];

    logic [IDX_W-1:0]    set_idx;
    logic [TAG_W-1:0]    req_tag;
    logic                hit, free;
    logic [WAY_W-1:0]    hit_way, free_way, victim_sel;

    // Single line write port, shared by write hits and installs.
    logic                arr_we;
    logic [WAY_W-1:0]    arr_way;
    logic [DATA_W-1:0]   arr_data;
    logic                arr_dirty;
    logic                rr_adv;

    assign set_idx = addr_q[IDX_W-1:0];
    assign req_tag = addr_q[ADDR_W-1:IDX_W];

    // Descending scan so the lowest-index matching/invalid way wins.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        free     = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set_idx][w]) begin
                free     = 1'b1;
                free_way = WAY_W'(w);
            end
        end
    end

    assign victim_sel = free ? free_way : rr_q[set_idx];

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        victim_d    = victim_q;
        fill_d      = fill_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_we      = 1'b0;
        arr_way     = victim_q;
        arr_data    = wdata_q;
        arr_dirty   = 1'b0;
        rr_adv      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    if (we_q) begin
                        arr_we    = 1'b1;
                        arr_way   = hit_way;
                        arr_data  = wdata_q;
                        arr_dirty = 1'b1;
                    end else begin
                        cpu_rdata_d = data_q[set_idx][hit_way];
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    victim_d = victim_sel;
                    // The pointer only advances when it actually chose the victim.
                    rr_adv   = !free;
                    if (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel]) begin
                        state_d = S_WB;
                    end else if (we_q) begin
                        state_d = S_INSTALL;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            // WB and FILL are entered with mem_req low: the first cycle raises
            // the request, which then holds until the ack edge and drops after it.
            S_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {tag_q[set_idx][victim_q], set_idx};
                    mem_wdata_d = data_q[set_idx][victim_q];
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = we_q ? S_INSTALL : S_FILL;
                end
            end
            S_FILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    fill_d    = mem_rdata;
                    state_d   = S_INSTALL;
                end
            end
            S_INSTALL: begin
                arr_we    = 1'b1;
                arr_way   = victim_q;
                arr_data  = we_q ? wdata_q : fill_q;
                arr_dirty = we_q;
                if (!we_q) begin
                    cpu_rdata_d = fill_q;
                end
                cpu_ready_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            victim_q    <= '0;
            fill_q      <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            victim_q    <= victim_d;
            fill_q      <= fill_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (arr_we) begin
                valid_q[set_idx][arr_way] <= 1'b1;
                dirty_q[set_idx][arr_way] <= arr_dirty;
            end
            if (rr_adv) begin
                rr_q[set_idx] <= rr_q[set_idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_q[set_idx][arr_way]  <= req_tag;
            data_q[set_idx][arr_way] <= arr_data;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef ASSOC_WB_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state_q == S_LOOKUP) && hit;
    assign miss_inc = (state_q == S_LOOKUP) && !hit;
    assign wb_inc   = (state_q == S_WB) && mem_req_q && mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (wb_inc)   wb_cnt_q   <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_wb_cache.sv
// Bench for assoc_wb_cache: directed scenarios followed by a randomized run,
// checked against a functional cache/memory reference model.
module tb_assoc_wb_cache;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int SETS   = 64;
    localparam int WAYS   = 4;

    logic              clk;
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
`ifdef ASSOC_WB_CACHE_STATS_EN
    logic [31:0]       hit_cnt, miss_cnt, wb_cnt;
`endif

    assoc_wb_cache #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef ASSOC_WB_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- backing memory: mem[a] = a unless written ----------------
    logic [DATA_W-1:0] mem_model [int];
    int                hold_ack  = 0;
    int                ack_delay = 2;
    int                n_wb = 0, n_fill = 0, req_cycles = 0;
    logic [ADDR_W-1:0] last_wb_addr = '0, last_fill_addr = '0;
    logic [DATA_W-1:0] last_wb_data = '0;

    function automatic logic [DATA_W-1:0] mem_rd(int a);
        if (mem_model.exists(a)) return mem_model[a];
        return DATA_W'(a);
    endfunction

    initial begin : responder
        int cnt;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) req_cycles++;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (!mem_req || hold_ack != 0) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_model[int'(mem_addr)] = mem_wdata;
                        n_wb++;
                        last_wb_addr = mem_addr;
                        last_wb_data = mem_wdata;
                    end else begin
                        mem_rdata = mem_rd(int'(mem_addr));
                        n_fill++;
                        last_fill_addr = mem_addr;
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Tracks which addresses each set holds and which are dirty; the data
    // itself is modelled as the coherent latest value per address.
    bit                r_valid [SETS][WAYS];
    bit                r_dirty [SETS][WAYS];
    int                r_tag   [SETS][WAYS];
    int                r_rr    [SETS];
    logic [DATA_W-1:0] coh [int];

    function automatic logic [DATA_W-1:0] coh_rd(int a);
        if (coh.exists(a)) return coh[a];
        return mem_rd(a);
    endfunction

    task automatic ref_reset();
        for (int s = 0; s < SETS; s++) begin
            r_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[s][w] = 0;
                r_dirty[s][w] = 0;
                r_tag[s][w]   = 0;
            end
        end
        coh.delete();
    endtask

    task automatic ref_access(input bit we, input int a, input logic [DATA_W-1:0] wd,
                              output bit hit, output bit wb, output int wb_a,
                              output logic [DATA_W-1:0] wb_d, output logic [DATA_W-1:0] erd);
        int s, t, hw, v;
        s = a % SETS; t = a / SETS;
        hit = 0; wb = 0; wb_a = 0; wb_d = '0; hw = 0; v = -1;
        erd = coh_rd(a);
        for (int w = 0; w < WAYS; w++)
            if (r_valid[s][w] && r_tag[s][w] == t) begin hit = 1; hw = w; end
        if (hit) begin
            if (we) r_dirty[s][hw] = 1;
        end else begin
            for (int w = 0; w < WAYS; w++)
                if (!r_valid[s][w] && v < 0) v = w;
            if (v < 0) begin
                v = r_rr[s];
                r_rr[s] = (r_rr[s] + 1) % WAYS;
            end
            if (r_valid[s][v] && r_dirty[s][v]) begin
                wb   = 1;
                wb_a = r_tag[s][v] * SETS + s;
                wb_d = coh_rd(wb_a);
            end
            r_valid[s][v] = 1;
            r_tag[s][v]   = t;
            r_dirty[s][v] = we;
        end
        if (we) coh[a] = wd;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          output logic [DATA_W-1:0] rd, output int cyc, output bit timeout);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = ADDR_W'($urandom); cpu_wdata = $urandom;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!cpu_ready && cyc < 300);
        timeout = !cpu_ready;
        rd = cpu_rdata;
    endtask

    task automatic run_check(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                             input string tag, output logic [DATA_W-1:0] rd, output int cyc);
        int wb0, f0, r0, wa;
        bit hit, wb, to;
        logic [DATA_W-1:0] wdat, erd;
        wb0 = n_wb; f0 = n_fill; r0 = req_cycles;
        ref_access(we, int'(a), wd, hit, wb, wa, wdat, erd);
        access(we, a, wd, rd, cyc, to);
        chk({tag, "_done"}, 64'(to), 64'(0));
        if (!we) chk({tag, "_rdata"}, 64'(rd), 64'(erd));
        chk({tag, "_nwb"}, 64'(n_wb - wb0), 64'(wb));
        chk({tag, "_nfill"}, 64'(n_fill - f0), 64'(!hit && !we));
        if (wb) begin
            chk({tag, "_wbaddr"}, 64'(last_wb_addr), 64'(wa));
            chk({tag, "_wbdata"}, 64'(last_wb_data), 64'(wdat));
        end
        if (!hit && !we) chk({tag, "_filladdr"}, 64'(last_fill_addr), 64'(a));
        if (hit) begin
            chk({tag, "_hitlat"}, 64'(cyc), 64'(1));
            chk({tag, "_hitnoreq"}, 64'(req_cycles - r0), 64'(0));
        end
        @(posedge clk);
        #1;
        if (!to) chk({tag, "_pulse"}, 64'(cpu_ready), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ref_reset();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        logic [DATA_W-1:0] rd, erd, wdat;
        int cyc, k, r0, f0, wa;
        bit stable, hit, wb;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ref_reset();
        repeat (3) @(negedge clk);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
        chk("rst_cpu_ready", 64'(cpu_ready), 64'(0));
        chk("rst_mem_req",   64'(mem_req),   64'(0));
        chk("rst_mem_we",    64'(mem_we),    64'(0));
        chk("rst_mem_addr",  64'(mem_addr),  64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        rst_n = 1'b1;

        // Test 1: cold read then hit.
        run_check(1'b0, 16'h0040, '0, "t1_cold", rd, cyc);
        chk("t1_cold_val", 64'(rd), 64'h40);
        chk("t1_cold_addr", 64'(last_fill_addr), 64'h40);
        run_check(1'b0, 16'h0040, '0, "t1_hit", rd, cyc);
        chk("t1_hit_val", 64'(rd), 64'h40);
        chk("t1_hit_lat", 64'(cyc), 64'(1));

        // Test 2: write hit stays in the cache.
        r0 = req_cycles;
        run_check(1'b1, 16'h0040, 32'hDEADBEEF, "t2_wr", rd, cyc);
        chk("t2_wr_noreq", 64'(req_cycles - r0), 64'(0));
        run_check(1'b0, 16'h0040, '0, "t2_rd", rd, cyc);
        chk("t2_rd_val", 64'(rd), 64'hDEADBEEF);
        chk("t2_mem_untouched", 64'(mem_rd(16'h0040)), 64'h40);

        // Test 3: fill set 0 from reset, then evict the dirty line.
        do_reset();
        r0 = req_cycles;
        run_check(1'b1, 16'h0000, 32'h12345678, "t3_wmiss", rd, cyc);
        chk("t3_wmiss_noreq", 64'(req_cycles - r0), 64'(0));
        run_check(1'b0, 16'h0040, '0, "t3_r40", rd, cyc);
        run_check(1'b0, 16'h0080, '0, "t3_r80", rd, cyc);
        run_check(1'b0, 16'h00C0, '0, "t3_rC0", rd, cyc);
        run_check(1'b0, 16'h0100, '0, "t3_r100", rd, cyc);
        chk("t3_wb_addr", 64'(last_wb_addr), 64'h0);
        chk("t3_wb_data", 64'(last_wb_data), 64'h12345678);
        chk("t3_mem0", 64'(mem_rd(0)), 64'h12345678);
        chk("t3_rd100", 64'(rd), 64'h100);
`ifdef ASSOC_WB_CACHE_STATS_EN
        chk("t6_hit_cnt",  64'(hit_cnt),  64'(0));
        chk("t6_miss_cnt", 64'(miss_cnt), 64'(5));
        chk("t6_wb_cnt",   64'(wb_cnt),   64'(1));
`endif

        // Test 4: ack withheld for 20 cycles during a fill.
        ref_access(1'b0, 16'h0200, '0, hit, wb, wa, wdat, erd);
        hold_ack = 1;
        f0 = n_fill;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin @(posedge clk); #1; k++; end
        chk("t4_req_up", 64'(mem_req), 64'(1));
        chk("t4_addr", 64'(mem_addr), 64'h200);
        chk("t4_we", 64'(mem_we), 64'(0));
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!mem_req || mem_addr !== 16'h0200 || mem_we || cpu_ready) stable = 0;
        end
        chk("t4_stable", 64'(stable), 64'(1));
        hold_ack = 0;
        k = 0;
        while (!cpu_ready && k < 20) begin @(posedge clk); #1; k++; end
        chk("t4_ready", 64'(cpu_ready), 64'(1));
        chk("t4_rdata", 64'(cpu_rdata), 64'(erd));
        chk("t4_nfill", 64'(n_fill - f0), 64'(1));
        @(posedge clk);
        #1;

        // Test 5: reset while a memory request is outstanding.
        hold_ack = 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin @(posedge clk); #1; k++; end
        chk("t5_req_up", 64'(mem_req), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_req_drop", 64'(mem_req), 64'(0));
        chk("t5_ready_low", 64'(cpu_ready), 64'(0));
        repeat (2) @(negedge clk);
        hold_ack = 0;
        rst_n = 1'b1;
        ref_reset();
        f0 = n_fill;
        run_check(1'b0, 16'h0040, '0, "t5_after", rd, cyc);
        chk("t5_after_miss", 64'(n_fill - f0), 64'(1));

        // Randomized run: few sets, many tags, to churn replacement and writebacks.
        for (int i = 0; i < 200; i++) begin
            logic [ADDR_W-1:0] a;
            bit we;
            a = ADDR_W'(($urandom_range(0, 7) * SETS) + $urandom_range(0, 1));
            we = 1'($urandom);
            ack_delay = $urandom_range(1, 4);
            run_check(we, a, $urandom, $sformatf("rnd%0d", i), rd, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
